// File: rtl/optical_bus_axil_pkg.sv
// rtl/optical_bus_axil_pkg.sv - shared constants for the optical-bus AXI4-Lite register slave
package optical_bus_axil_pkg;

    localparam int NUM_REGS = 4;

    // Byte offsets of the four control registers
    localparam logic [3:0] REG0_OFS = 4'h0;
    localparam logic [3:0] REG1_OFS = 4'h4;
    localparam logic [3:0] REG2_OFS = 4'h8;
    localparam logic [3:0] REG3_OFS = 4'hC;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/optical_bus_axil_slave_if.sv
// rtl/optical_bus_axil_slave_if.sv - AXI4-Lite S00_AXI channel bundle with master/slave modports
//
// Carries the AW, W, B, AR and R channels. Clock and reset are not part of
// the bundle; they stay plain ports on the modules that use it.
interface optical_bus_axil_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/optical_bus_reg_bank.sv
// rtl/optical_bus_reg_bank.sv - four 32-bit control registers with byte-strobed write port
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_idx        commit enable and target word
//   wr_data/wr_strb     write data and per-byte enables
//   rd_idx/rd_data      combinational read mux
//   regs_o              all registers, reg k at [32k+31:32k]
module optical_bus_reg_bank
    import optical_bus_axil_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [1:0]               wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [1:0]               rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
        assign regs_o[32*k +: 32] = regs[k];
    end

endmodule

// File: rtl/optical_bus_axil_slave.sv
// rtl/optical_bus_axil_slave.sv - AXI4-Lite slave front end exposing four control registers
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   axi                         S00_AXI channels (slave modport)
//   regs_o                      register contents, reg k at [32k+31:32k]
//   reg_wr_o                    one-cycle pulse after reg k is committed
module optical_bus_axil_slave
    import optical_bus_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    optical_bus_axil_slave_if.slave    axi,
    output logic [NUM_REGS*32-1:0]     regs_o,
    output logic [NUM_REGS-1:0]        reg_wr_o
);

    logic        aw_held;
    logic [1:0]  aw_idx;
    logic        w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] rd_data;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;

    assign aw_hs  = axi.S_AXI_AWVALID && !aw_held;
    assign w_hs   = axi.S_AXI_WVALID && !w_held;
    assign ar_hs  = axi.S_AXI_ARVALID && !rvalid;
    // A commit may overlap the B handshake of the previous write, so the
    // response slot frees and refills on the same edge.
    assign commit = aw_held && w_held && (!bvalid || axi.S_AXI_BREADY);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            reg_wr_o <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= axi.S_AXI_AWADDR[3:2];
            end else if (commit) begin
                aw_held <= 1'b0;
            end

            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= axi.S_AXI_WDATA;
                w_strb <= axi.S_AXI_WSTRB;
            end else if (commit) begin
                w_held <= 1'b0;
            end

            if (commit) begin
                bvalid <= 1'b1;
            end else if (axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end

            reg_wr_o <= commit ? (NUM_REGS'(1) << aw_idx) : '0;

            // rd_data is sampled before the bank's own update on this edge,
            // so a colliding read returns the pre-write value.
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
            end else if (axi.S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    optical_bus_reg_bank u_reg_bank (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .wr_en   (commit),
        .wr_idx  (aw_idx),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_idx  (axi.S_AXI_ARADDR[3:2]),
        .rd_data (rd_data),
        .regs_o  (regs_o)
    );

    assign axi.S_AXI_AWREADY = !aw_held;
    assign axi.S_AXI_WREADY  = !w_held;
    assign axi.S_AXI_BVALID  = bvalid;
    assign axi.S_AXI_BRESP   = AXI_RESP_OKAY;
    assign axi.S_AXI_ARREADY = !rvalid;
    assign axi.S_AXI_RVALID  = rvalid;
    assign axi.S_AXI_RDATA   = rdata;
    assign axi.S_AXI_RRESP   = AXI_RESP_OKAY;

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{axi.S_AXI_AWPROT, axi.S_AXI_ARPROT,
                         axi.S_AXI_AWADDR[1:0], axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_optical_bus_axil_slave.sv
// tb/tb_optical_bus_axil_slave.sv - directed self-checking bench for optical_bus_axil_slave
module tb_optical_bus_axil_slave;
    import optical_bus_axil_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [127:0] regs;
    logic [3:0]   reg_wr;
    int           checks;
    int           errors;

    optical_bus_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

    optical_bus_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .axi           (axi),
        .regs_o        (regs),
        .reg_wr_o      (reg_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] bresp);
        bit aw_go, w_go, done;
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_BREADY  = 1'b1;
        bresp = 2'bxx;
        for (int c = 0; c < 50 && (axi.S_AXI_AWVALID || axi.S_AXI_WVALID); c++) begin
            @(negedge clk);
            aw_go = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_go  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_go) axi.S_AXI_AWVALID = 1'b0;
            if (w_go)  axi.S_AXI_WVALID  = 1'b0;
        end
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (axi.S_AXI_BVALID) begin
                bresp = axi.S_AXI_BRESP;
                done = 1'b1;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!done || axi.S_AXI_AWVALID || axi.S_AXI_WVALID) begin
            errors++;
            $display("FAIL write_timeout addr=%h: got no B response, required one within 50 cycles", addr);
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] rresp);
        bit ar_go, done;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b1;
        data = 'x;
        rresp = 'x;
        for (int c = 0; c < 50 && axi.S_AXI_ARVALID; c++) begin
            @(negedge clk);
            ar_go = axi.S_AXI_ARREADY;
            @(posedge clk); #1;
            if (ar_go) axi.S_AXI_ARVALID = 1'b0;
        end
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (axi.S_AXI_RVALID) begin
                data = axi.S_AXI_RDATA;
                rresp = axi.S_AXI_RRESP;
                done = 1'b1;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!done || axi.S_AXI_ARVALID) begin
            errors++;
            $display("FAIL read_timeout addr=%h: got no R response, required one within 50 cycles", addr);
            axi.S_AXI_ARVALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_handshake got aw/w/ar/b/r=%b required 11100",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID});
        end
        checks++;
        if (regs !== 128'h0 || reg_wr !== 4'h0 || axi.S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got regs=%h reg_wr=%b rdata=%h required all zero", regs, reg_wr, axi.S_AXI_RDATA);
        end
    endtask

    task automatic test_seq_write_read();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [3:0]  ofs [4];
        ofs[0] = REG0_OFS; ofs[1] = REG1_OFS; ofs[2] = REG2_OFS; ofs[3] = REG3_OFS;
        for (int k = 0; k < 4; k++) begin
            axi_write(ofs[k], 32'(k + 1), 4'hF, resp);
            checks++;
            if (resp !== 2'b00) begin
                errors++;
                $display("FAIL seq_bresp[%0d] got %b required 00", k, resp);
            end
        end
        checks++;
        if (regs !== 128'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL seq_regs got %h required 00000004000000030000000200000001", regs);
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(ofs[k], rd, resp);
            checks++;
            if (rd !== 32'(k + 1) || resp !== 2'b00) begin
                errors++;
                $display("FAIL seq_rdata[%0d] got %h/%b required %h/00", k, rd, resp, 32'(k + 1));
            end
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        axi.S_AXI_BREADY  = 1'b1;
        axi.S_AXI_WDATA   = 32'hDEADBEEF;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.S_AXI_WREADY !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_wready got %b required 0", axi.S_AXI_WREADY);
        end
        @(negedge clk);
        @(negedge clk);
        axi.S_AXI_AWADDR  = REG2_OFS;
        axi.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0 || reg_wr !== 4'b0000) begin
            errors++;
            $display("FAIL wfirst_early got bvalid=%b reg_wr=%b required 0/0000", axi.S_AXI_BVALID, reg_wr);
        end
        @(negedge clk);
        checks++;
        if (axi.S_AXI_BVALID !== 1'b1 || reg_wr !== 4'b0100 || regs[95:64] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wfirst_commit got bvalid=%b reg_wr=%b reg2=%h required 1/0100/deadbeef",
                     axi.S_AXI_BVALID, reg_wr, regs[95:64]);
        end
        @(negedge clk);
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0 || reg_wr !== 4'b0000) begin
            errors++;
            $display("FAIL wfirst_pulse got bvalid=%b reg_wr=%b required 0/0000", axi.S_AXI_BVALID, reg_wr);
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0]  resp;
        logic [31:0] rd;
        axi_write(REG1_OFS, 32'h11223344, 4'hF, resp);
        axi_write(REG1_OFS, 32'hAABBCCDD, 4'b0101, resp);
        axi_read(REG1_OFS, rd, resp);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL partial_strobe got %h required 11bb33dd", rd);
        end
    endtask

    task automatic test_backpressure();
        bit aw_go, w_go;
        int bad;
        @(negedge clk);
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;
        axi.S_AXI_AWADDR  = REG0_OFS;
        axi.S_AXI_WDATA   = 32'h12345678;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_ARADDR  = REG2_OFS;
        axi.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        // second write to reg1 captured while B of the first is stalled
        axi.S_AXI_AWADDR  = REG1_OFS;
        axi.S_AXI_WDATA   = 32'hCAFEF00D;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        for (int c = 0; c < 20 && (axi.S_AXI_AWVALID || axi.S_AXI_WVALID); c++) begin
            @(negedge clk);
            aw_go = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_go  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_go) axi.S_AXI_AWVALID = 1'b0;
            if (w_go)  axi.S_AXI_WVALID  = 1'b0;
        end
        checks++;
        if (axi.S_AXI_AWVALID || axi.S_AXI_WVALID) begin
            errors++;
            $display("FAIL bp_capture got second write not accepted, required capture while B stalled");
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 5'b11000
                || axi.S_AXI_RDATA !== 32'hDEADBEEF || regs[63:0] !== 64'h11BB33DD_12345678) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stall got %0d bad cycles (b/r/aw/w/ar=%b rdata=%h regs01=%h) required 0 with 11000/deadbeef/11bb33dd12345678",
                     bad, {axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY},
                     axi.S_AXI_RDATA, regs[63:0]);
        end
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (axi.S_AXI_BVALID !== 1'b1 || reg_wr !== 4'b0010 || regs[63:32] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bp_second_commit got bvalid=%b reg_wr=%b reg1=%h required 1/0010/cafef00d",
                     axi.S_AXI_BVALID, reg_wr, regs[63:32]);
        end
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0 || axi.S_AXI_RVALID !== 1'b0 || axi.S_AXI_ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got bvalid=%b rvalid=%b arready=%b required 0/0/1",
                     axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_ARREADY);
        end
    endtask

    task automatic test_collision();
        logic [1:0]  resp;
        logic [31:0] rd;
        @(negedge clk);
        axi.S_AXI_BREADY  = 1'b1;
        axi.S_AXI_RREADY  = 1'b1;
        axi.S_AXI_AWADDR  = REG3_OFS;
        axi.S_AXI_WDATA   = 32'h55;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        axi.S_AXI_ARADDR  = REG3_OFS;
        axi.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.S_AXI_RVALID !== 1'b1 || axi.S_AXI_RDATA !== 32'h4 || regs[127:96] !== 32'h55) begin
            errors++;
            $display("FAIL collision got rvalid=%b rdata=%h reg3=%h required 1/00000004/00000055",
                     axi.S_AXI_RVALID, axi.S_AXI_RDATA, regs[127:96]);
        end
        @(negedge clk);
        axi_read(REG3_OFS, rd, resp);
        checks++;
        if (rd !== 32'h55) begin
            errors++;
            $display("FAIL collision_reread got %h required 00000055", rd);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        axi.S_AXI_RREADY  = 1'b0;
        axi.S_AXI_AWADDR  = REG0_OFS;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_ARADDR  = REG1_OFS;
        axi.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.S_AXI_AWREADY !== 1'b0 || axi.S_AXI_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got awready=%b rvalid=%b required 0/1", axi.S_AXI_AWREADY, axi.S_AXI_RVALID);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 5'b11100
            || axi.S_AXI_RDATA !== 32'h0 || regs !== 128'h0 || reg_wr !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_async got aw/w/ar/b/r=%b rdata=%h regs=%h reg_wr=%b required 11100/0/0/0",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID, axi.S_AXI_RVALID},
                     axi.S_AXI_RDATA, regs, reg_wr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        axi.S_AXI_RREADY = 1'b1;
        axi.S_AXI_BREADY = 1'b1;
        // a lone W must not pair with the AW discarded by reset
        axi.S_AXI_WDATA  = 32'h99999999;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_WVALID = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (axi.S_AXI_BVALID || axi.S_AXI_RVALID || reg_wr != 4'h0) seen++;
        end
        checks++;
        if (seen != 0 || regs !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_no_resp got %0d response cycles regs=%h required 0 and all-zero regs", seen, regs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWPROT  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b1;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARPROT  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset();
        test_seq_write_read();
        test_w_before_aw();
        test_partial_strobe();
        test_backpressure();
        test_collision();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/optical_bus_axil_slave.md
# optical_bus_axil_slave

AXI4-Lite slave front end of the optical-bus IP: terminates the S00_AXI port driven by the PS/VIP master and exposes four 32-bit read/write control registers to the optical-bus core. Write address and write data channels are accepted independently, merged with byte strobes, committed, and answered on B. Reads return the register contents on R. Always responds OKAY.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte-address width. Bits [3:2] select the word; bits [1:0] are ignored.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- regs_o  out  128  register contents; reg k is at bits [32k+31:32k].
- reg_wr_o  out  4  one-cycle pulse on the cycle after reg k is committed.

## Operation
- **Write capture.**
  - AWREADY = !aw_held. On an AW handshake, latch the word index and set aw_held.
  - WREADY = !w_held. On a W handshake, latch WDATA and WSTRB and set w_held.
  - AW and W may arrive in either order, or together.
- **Commit.** When aw_held && w_held && (!BVALID || BREADY):
  - Write each byte of the selected register whose WSTRB bit is set. Bytes with a clear strobe keep their value.
  - Clear aw_held and w_held. Set BVALID. Pulse reg_wr_o[index].
- **Write response.** BVALID stays high until the B handshake.
  - A new AW and W may be captured while BVALID is high.
  - Their commit waits for the B handshake, or commits on the same edge as that handshake.
- **Read.** ARREADY = !RVALID.
  - On an AR handshake, RDATA ← the selected register and RVALID ← 1.
  - RDATA and RVALID are held stable until the R handshake.
- **Read/write collision.** If an AR handshake and a commit to the same word occur on the same edge, RDATA returns the pre-write value.
- The read and write paths are fully independent. There is no arbitration.

## Timing
- **Reset (ARESETN low, asynchronous).**
  - All registers are 0.
  - AWREADY = 1, WREADY = 1, ARREADY = 1.
  - BVALID = 0, RVALID = 0, RDATA = 0, reg_wr_o = 0.
  - aw_held and w_held are cleared.
  - Reset mid-transaction discards every pending AW, W, B and R. No response is issued for them afterwards.
- **Write latency.**
  - AW and W handshaking together at edge t: commit at edge t+1; BVALID, regs_o and reg_wr_o are visible after t+1.
  - Split arrival: the commit occurs one edge after the later handshake.
- **Write throughput.** With BREADY held high, a write completes every 2 cycles.
- **Read latency.** RVALID is visible after the AR handshake edge (1 cycle).
  - With RREADY held high, one read completes every 2 cycles.
- **Backpressure.**
  - BVALID held by BREADY low: aw_held and w_held may still fill. AWREADY and WREADY then drop until the commit.
  - RREADY low: ARREADY stays low.
- All outputs are registered. There is no combinational path from a VALID or READY input to any output.

## Structure
- **Package optical_bus_axil_pkg** contains:
  - The word offsets REG0_OFS = 4'h0, REG1_OFS = 4'h4, REG2_OFS = 4'h8, REG3_OFS = 4'hC.
  - AXI_RESP_OKAY = 2'b00.
  - NUM_REGS = 4.
- **Sub-module optical_bus_reg_bank** holds the four registers. Its inputs and outputs:
  - Write port: index, data, strobe, enable.
  - Combinational read mux.
  - Output regs_o.
- The top level holds the channel handshake logic.

## Test plan
- **Sequential write and readback.** Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, each AXI4LITE write with all strobes set. Read all four back.
  - Required: BRESP = OKAY each time, RDATA = 1, 2, 3, 4, and regs_o = 0x00000004_00000003_00000002_00000001.
- **W before AW.** Drive W 0xDEADBEEF to 0x8 three cycles before AW.
  - Required: WREADY drops after the W handshake, BVALID rises one edge after the AW handshake, reg_wr_o = 4'b0100 for one cycle, and reg2 = 0xDEADBEEF.
- **Partial strobes.** reg1 = 0x11223344, then write 0xAABBCCDD with WSTRB = 4'b0101.
  - Required: reading 0x4 returns 0x11BB33DD.
- **Backpressure.** Hold BREADY and RREADY low for 10 cycles.
  - Required: BVALID and RVALID stay high with stable data, the second write stalls with AWREADY = WREADY = 0, ARREADY = 0, and no responses are lost after the READYs rise.
- **Collision.** AR handshake on 0xC on the same edge as a commit of 0x55 to 0xC, where reg3 was 0x4.
  - Required: RDATA = 0x4, and a following read returns 0x55.
- **Reset mid-operation.** Assert ARESETN low while aw_held = 1 and RVALID = 1.
  - Required: all outputs return to their reset values asynchronously, regs_o = 0, and no B or R response appears after release.
